// File: rtl/ram_pkg.sv
// Shared constants, state type and address helper for the 128x8 RAM initiator.
package ram_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 128;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StRdTail,
    StTurn
  } ram_st_t;

  // Increment within the RAM address space, wrapping DEPTH-1 back to 0.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/ram_master_if.sv
// Request, write-data, response and RAM strobe/address signals of ram_master.
interface ram_master_if;
  import ram_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_len;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_last;
  logic          mem_cs;
  logic          mem_wr_e;
  logic          mem_o_e;
  logic [AW-1:0] mem_addr;

  modport master (
    input  req_valid, req_we, req_addr, req_len, wvalid, wdata,
    output req_ready, wready, rsp_valid, rsp_rdata, rsp_last,
    output mem_cs, mem_wr_e, mem_o_e, mem_addr
  );

  modport slave (
    output req_valid, req_we, req_addr, req_len, wvalid, wdata,
    input  req_ready, wready, rsp_valid, rsp_rdata, rsp_last,
    input  mem_cs, mem_wr_e, mem_o_e, mem_addr
  );

endinterface

// File: rtl/ram_master.sv
// Burst read/write initiator for a single-port synchronous RAM with a shared
// tri-state data bus; read data and write completions return on a response port.
module ram_master
  import ram_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  ram_master_if.master    bus,
  inout  wire  [DW-1:0]   io_mem_data
);

  ram_st_t       r_state, w_state_nxt;
  logic [AW-1:0] r_cur_addr, w_cur_addr_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic          r_rd_pend;
  logic          r_rsp_valid, r_rsp_last;
  logic [DW-1:0] r_rsp_rdata;

  logic          w_req_ready, w_wready;
  logic          w_cs, w_wr_e, w_o_e;
  logic [AW-1:0] w_mem_addr;
  logic          w_wr_last;

  always_comb begin
    w_state_nxt    = r_state;
    w_cur_addr_nxt = r_cur_addr;
    w_cnt_nxt      = r_cnt;
    w_req_ready    = 1'b0;
    w_wready       = 1'b0;
    w_cs           = 1'b0;
    w_wr_e         = 1'b0;
    w_o_e          = 1'b0;
    w_mem_addr     = '0;
    w_wr_last      = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_req_ready = i_rst_n;
        if (bus.req_valid) begin
          w_cur_addr_nxt = bus.req_addr % AW'(DEPTH);
          w_cnt_nxt      = bus.req_len;
          w_state_nxt    = bus.req_we ? StWr : StRd;
        end
      end
      StWr: begin
        w_wready = 1'b1;
        if (bus.wvalid) begin
          w_cs           = 1'b1;
          w_wr_e         = 1'b1;
          w_mem_addr     = r_cur_addr;
          w_cur_addr_nxt = next_addr(r_cur_addr);
          w_cnt_nxt      = r_cnt - 1'b1;
          if (r_cnt == '0) begin
            w_wr_last   = 1'b1;
            w_state_nxt = StIdle;
          end
        end
      end
      StRd: begin
        w_cs       = 1'b1;
        w_mem_addr = r_cur_addr;
        // Previous word is on the bus while the RAM latches this address.
        w_o_e      = r_rd_pend;
        w_cnt_nxt  = r_cnt - 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = StRdTail;
        end else begin
          w_cur_addr_nxt = next_addr(r_cur_addr);
        end
      end
      StRdTail: begin
        w_cs        = 1'b1;
        w_o_e       = 1'b1;
        w_mem_addr  = r_cur_addr;
        w_state_nxt = StTurn;
      end
      StTurn: begin
        // Dead cycle so a following write never fights the RAM output.
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cur_addr  <= '0;
      r_cnt       <= '0;
      r_rd_pend   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_addr  <= w_cur_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rd_pend   <= (r_state == StRd);
      r_rsp_valid <= w_o_e | w_wr_last;
      r_rsp_last  <= (w_o_e && (r_state == StRdTail)) | w_wr_last;
      if (w_o_e) begin
        r_rsp_rdata <= io_mem_data;
      end else if (w_wr_last) begin
        r_rsp_rdata <= '0;
      end
    end
  end

  assign io_mem_data   = w_wr_e ? bus.wdata : {DW{1'bz}};

  assign bus.req_ready = w_req_ready;
  assign bus.wready    = w_wready;
  assign bus.mem_cs    = w_cs;
  assign bus.mem_wr_e  = w_wr_e;
  assign bus.mem_o_e   = w_o_e;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master against a behavioural 128x8 synchronous RAM.
module tb_ram_master;

  typedef struct {
    logic           we;
    logic [7:0]     addr;
    int             beats;
    logic           stall;
    logic [3:0][7:0] ea;   // expected mem_addr per beat
    logic [3:0][7:0] dat;  // write data / expected read data per beat
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  ram_master_if bus ();
  wire [7:0] mem_data;

  ram_master u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .io_mem_data (mem_data)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: address latched on the edge, output enabled by o_e.
  logic [7:0] ram [128];
  logic [7:0] ram_q;
  wire        ram_oe = bus.mem_cs & bus.mem_o_e & ~bus.mem_wr_e;
  assign mem_data = ram_oe ? ram_q : 8'hzz;

  always @(posedge clk) begin
    if (bus.mem_cs && bus.mem_wr_e) ram[bus.mem_addr[6:0]] <= mem_data;
    if (bus.mem_cs && !bus.mem_wr_e)
      ram_q <= $isunknown(ram[bus.mem_addr[6:0]]) ? 8'h00 : ram[bus.mem_addr[6:0]];
  end

  always @(negedge clk) begin
    if (rst_n && bus.mem_o_e) begin
      n_cmp++;
      if (bus.mem_wr_e) begin
        n_fail++;
        $display("FAIL bus_contention: mem_wr_e=%0b with mem_o_e=1, required 0", bus.mem_wr_e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic we, input logic [7:0] addr, input int beats);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_len   = 4'(beats - 1);
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_write(input vec_t v);
    start_req(1'b1, v.addr, v.beats);
    for (int i = 0; i < v.beats; i++) begin
      if (v.stall) begin
        bus.wvalid = 1'b0;
        @(negedge clk);
        check("wr_stall_wr_e", 32'(bus.mem_wr_e), 0);
        check("wr_stall_wready", 32'(bus.wready), 1);
        @(posedge clk); #1;
      end
      bus.wvalid = 1'b1;
      bus.wdata  = v.dat[i];
      @(negedge clk);
      check("wr_wr_e", 32'(bus.mem_wr_e), 1);
      check("wr_cs", 32'(bus.mem_cs), 1);
      check("wr_addr", 32'(bus.mem_addr), 32'(v.ea[i]));
      check("wr_bus_data", 32'(mem_data), 32'(v.dat[i]));
      check("wr_no_rsp", 32'(bus.rsp_valid), 0);
      @(posedge clk); #1;
      bus.wvalid = 1'b0;
    end
    @(negedge clk);
    check("wr_rsp_valid", 32'(bus.rsp_valid), 1);
    check("wr_rsp_last", 32'(bus.rsp_last), 1);
    check("wr_rsp_rdata", 32'(bus.rsp_rdata), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input vec_t v);
    start_req(1'b0, v.addr, v.beats);
    for (int idx = 0; idx <= v.beats + 1; idx++) begin
      @(negedge clk);
      check("rd_ready_busy", 32'(bus.req_ready), 0);
      if (idx < v.beats) begin
        check("rd_addr", 32'(bus.mem_addr), 32'(v.ea[idx]));
        check("rd_cs", 32'(bus.mem_cs), 1);
        check("rd_o_e", 32'(bus.mem_o_e), (idx > 0) ? 1 : 0);
      end else if (idx == v.beats) begin
        check("rd_tail_cs", 32'(bus.mem_cs), 1);
        check("rd_tail_o_e", 32'(bus.mem_o_e), 1);
      end else begin
        check("rd_turn_cs", 32'(bus.mem_cs), 0);
      end
      if (idx >= 2) begin
        check("rd_rsp_valid", 32'(bus.rsp_valid), 1);
        check("rd_rsp_rdata", 32'(bus.rsp_rdata), 32'(v.dat[idx-2]));
        check("rd_rsp_last", 32'(bus.rsp_last), (idx - 2 == v.beats - 1) ? 1 : 0);
      end else begin
        check("rd_rsp_early", 32'(bus.rsp_valid), 0);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("rd_idle_rsp", 32'(bus.rsp_valid), 0);
    check("rd_idle_ready", 32'(bus.req_ready), 1);
    @(posedge clk); #1;
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wvalid    = 1'b0;
    bus.wdata     = '0;

    //        we    addr   beats stall  ea {3,2,1,0}                 dat {3,2,1,0}
    vecs[0] = '{1'b1, 8'h10, 1, 1'b0, {8'h00, 8'h00, 8'h00, 8'h10}, {8'h00, 8'h00, 8'h00, 8'hA5}};
    vecs[1] = '{1'b0, 8'h10, 1, 1'b0, {8'h00, 8'h00, 8'h00, 8'h10}, {8'h00, 8'h00, 8'h00, 8'hA5}};
    vecs[2] = '{1'b1, 8'h7E, 4, 1'b0, {8'h01, 8'h00, 8'h7F, 8'h7E}, {8'h04, 8'h03, 8'h02, 8'h01}};
    vecs[3] = '{1'b0, 8'h7E, 4, 1'b0, {8'h01, 8'h00, 8'h7F, 8'h7E}, {8'h04, 8'h03, 8'h02, 8'h01}};
    vecs[4] = '{1'b1, 8'hC0, 2, 1'b0, {8'h00, 8'h00, 8'h41, 8'h40}, {8'h00, 8'h00, 8'hC3, 8'h5A}};
    vecs[5] = '{1'b0, 8'h40, 2, 1'b0, {8'h00, 8'h00, 8'h41, 8'h40}, {8'h00, 8'h00, 8'hC3, 8'h5A}};
    vecs[6] = '{1'b1, 8'h20, 3, 1'b1, {8'h00, 8'h22, 8'h21, 8'h20}, {8'h00, 8'h33, 8'h22, 8'h11}};
    vecs[7] = '{1'b0, 8'h20, 3, 1'b0, {8'h00, 8'h22, 8'h21, 8'h20}, {8'h00, 8'h33, 8'h22, 8'h11}};

    // Reset values
    #3;
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_wready", 32'(bus.wready), 0);
    check("rst_cs", 32'(bus.mem_cs), 0);
    check("rst_wr_e", 32'(bus.mem_wr_e), 0);
    check("rst_o_e", 32'(bus.mem_o_e), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_last", 32'(bus.rsp_last), 0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.req_ready), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].we) do_write(vecs[i]);
      else            do_read(vecs[i]);
    end

    // Request held during a read, changed to a write once the read is accepted
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h7E;
    bus.req_len   = 4'd1;
    @(negedge clk);
    check("busy_accept_rd", 32'(bus.req_ready), 1);
    @(posedge clk); #1;
    bus.req_we   = 1'b1;
    bus.req_addr = 8'h30;
    bus.req_len  = 4'd0;
    bus.wdata    = 8'h77;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("busy_ready_low", 32'(bus.req_ready), 0);
      if (k == 3) begin
        check("turn_cs", 32'(bus.mem_cs), 0);
        check("turn_wr_e", 32'(bus.mem_wr_e), 0);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("busy_accept_wr", 32'(bus.req_ready), 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.wvalid    = 1'b1;
    @(negedge clk);
    check("busy_wr_e", 32'(bus.mem_wr_e), 1);
    check("busy_wr_addr", 32'(bus.mem_addr), 'h30);
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    @(negedge clk);
    check("busy_wr_rsp", 32'(bus.rsp_valid), 1);
    check("busy_wr_last", 32'(bus.rsp_last), 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("no_second_accept", 32'(bus.mem_cs), 0);
    end
    @(posedge clk); #1;
    v = '{1'b0, 8'h30, 1, 1'b0, {8'h00, 8'h00, 8'h00, 8'h30}, {8'h00, 8'h00, 8'h00, 8'h77}};
    do_read(v);

    // Reset during beat 2 of an 8-beat read
    start_req(1'b0, 8'h7E, 8);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs", 32'(bus.mem_cs), 0);
    check("mid_rst_o_e", 32'(bus.mem_o_e), 0);
    check("mid_rst_wr_e", 32'(bus.mem_wr_e), 0);
    check("mid_rst_ready", 32'(bus.req_ready), 0);
    check("mid_rst_rsp", 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    check("mid_rst_rsp2", 32'(bus.rsp_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(bus.req_ready), 1);
    check("rel_rsp", 32'(bus.rsp_valid), 0);
    check("rel_cs", 32'(bus.mem_cs), 0);
    @(posedge clk); #1;
    v = '{1'b1, 8'h05, 2, 1'b0, {8'h00, 8'h00, 8'h06, 8'h05}, {8'h00, 8'h00, 8'h3D, 8'h9C}};
    do_write(v);
    v.we = 1'b0;
    do_read(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
